// File: rtl/sseg_pkg.sv
// Shared constants and scan-FSM state type for the 7-segment display scanner.
package sseg_pkg;

  localparam int unsigned MAX_DIG = 8;

  localparam logic [6:0]         SSEG_BLANK = 7'b1111111;
  localparam logic [MAX_DIG-1:0] AN_OFF     = '1;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/sseg_scan_ctrl_dec.sv
// Combinational nibble to active-low 7-segment pattern (a..g, 0 = lit).
module bcd_to_sseg_dec
  import sseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [0:6] seg_o
);

  // Undefined nibbles fall through to the blank default.
  always_comb begin
    seg_o = SSEG_BLANK;
    case (nib_i)
      4'h0: seg_o = 7'b0000001;
      4'h1: seg_o = 7'b1001111;
      4'h2: seg_o = 7'b0010010;
      4'h3: seg_o = 7'b0000110;
      4'h4: seg_o = 7'b1001100;
      4'h5: seg_o = 7'b0100100;
      4'h6: seg_o = 7'b0100000;
      4'h7: seg_o = 7'b0001111;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0000100;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b1100000;
      4'hC: seg_o = 7'b0110001;
      4'hD: seg_o = 7'b1000010;
      4'hE: seg_o = 7'b0110000;
      4'hF: seg_o = 7'b0111000;
      default: seg_o = SSEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed scan controller: one blank clk plus TICK_DIV lit clks per digit,
// with a double-buffered display word committed only at frame boundaries.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int unsigned NDIG     = 8,
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] value_in,
  input  logic              value_load,
  input  logic [NDIG-1:0]   dig_en,
  output logic [NDIG-1:0]   an,
  output logic [0:6]        sseg,
  output logic              load_ack,
  output logic              frame_done
);

  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  scan_state_e       state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [4*NDIG-1:0] active_q, pending_q;
  logic              pend_vld_q;
  logic [NDIG-1:0]   an_q, an_d;
  logic [0:6]        sseg_q, sseg_d, dec_seg;
  logic [3:0]        nib;
  logic              tick, last_dig, boundary;

  always_comb begin
    tick     = (state_q == DRIVE) && (cnt_q == CNT_W'(TICK_DIV - 1));
    last_dig = (idx_q == IDX_W'(NDIG - 1));
    boundary = tick && last_dig && !rst;
    nib      = '0;
    an_d     = AN_OFF[NDIG-1:0];
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib = active_q[4*k +: 4];
        if (state_q == DRIVE) an_d[k] = ~dig_en[k];
      end
    end
  end

  bcd_to_sseg_dec u_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  assign sseg_d     = (state_q == DRIVE) ? dec_seg : SSEG_BLANK;
  assign frame_done = boundary;
  assign load_ack   = boundary && (pend_vld_q || value_load);
  assign an         = an_q;
  assign sseg       = sseg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BLANK;
      idx_q      <= '0;
      cnt_q      <= '0;
      active_q   <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      an_q       <= AN_OFF[NDIG-1:0];
      sseg_q     <= SSEG_BLANK;
    end else begin
      an_q   <= an_d;
      sseg_q <= sseg_d;

      case (state_q)
        BLANK: begin
          state_q <= DRIVE;
          cnt_q   <= '0;
        end
        DRIVE: begin
          if (tick) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= last_dig ? '0 : idx_q + IDX_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= BLANK;
      endcase

      // A load landing on the boundary bypasses the pending buffer entirely.
      if (boundary) begin
        if (value_load)      active_q <= value_in;
        else if (pend_vld_q) active_q <= pending_q;
        pend_vld_q <= 1'b0;
        pending_q  <= '0;
      end else if (value_load) begin
        pending_q  <= value_in;
        pend_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with NDIG=4, TICK_DIV=4 (slot 5 clks, frame 20 clks).
module tb_sseg_scan_ctrl;

  localparam int unsigned NDIG     = 4;
  localparam int unsigned TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic        value_load;
  logic [3:0]  dig_en;
  logic [3:0]  an;
  logic [0:6]  sseg;
  logic        load_ack;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acks   = 0;
  int fdones = 0;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.NDIG(NDIG), .TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .value_load (value_load),
    .dig_en     (dig_en),
    .an         (an),
    .sseg       (sseg),
    .load_ack   (load_ack),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic [3:0] an_e, input logic [0:6] seg_e);
    chk({tag, "_an"}, {28'd0, an}, {28'd0, an_e});
    chk({tag, "_sseg"}, {25'd0, sseg}, {25'd0, seg_e});
  endtask

  // cyc = index of the last rising edge since reset release; sampled on the falling edge.
  task automatic adv();
    @(negedge clk);
    cyc++;
  endtask

  task automatic adv_to(input int c);
    while (cyc < c) adv();
  endtask

  initial begin
    rst        = 1'b1;
    value_in   = '0;
    value_load = 1'b0;
    dig_en     = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_sseg", {25'd0, sseg}, 32'h7F);
    chk("rst_ack", {31'd0, load_ack}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);

    // Test 1: blank slot then digit 0 showing "0"
    rst = 1'b0;
    cyc = -1;
    adv_to(0);
    chk("t1_blank_an", {28'd0, an}, 32'hF);
    adv_to(1);
    chk_slot("t1_d0_first", 4'b1110, 7'b0000001);
    value_in   = 16'h3210;
    value_load = 1'b1;
    adv_to(2);
    value_load = 1'b0;
    adv_to(4);
    chk_slot("t1_d0_last", 4'b1110, 7'b0000001);
    adv_to(5);
    chk("t1_blank2_an", {28'd0, an}, 32'hF);

    // Test 2: pending word held until the frame boundary
    adv_to(6);
    chk_slot("t2_old_d1", 4'b1101, 7'b0000001);
    adv_to(17);
    chk("t2_fd_early", {31'd0, frame_done}, 32'd0);
    adv_to(18);
    chk("t2_fd", {31'd0, frame_done}, 32'd1);
    chk("t2_ack", {31'd0, load_ack}, 32'd1);
    adv_to(19);
    chk("t2_fd_off", {31'd0, frame_done}, 32'd0);
    chk("t2_ack_off", {31'd0, load_ack}, 32'd0);
    chk("t2_d3_an", {28'd0, an}, 32'h7);
    adv_to(21); chk_slot("t2_d0", 4'b1110, 7'b0000001);
    adv_to(26); chk_slot("t2_d1", 4'b1101, 7'b1001111);
    adv_to(31); chk_slot("t2_d2", 4'b1011, 7'b0010010);
    adv_to(36); chk_slot("t2_d3", 4'b0111, 7'b0000110);
    adv_to(38);
    chk("t2_fd2", {31'd0, frame_done}, 32'd1);
    chk("t2_noack2", {31'd0, load_ack}, 32'd0);

    // Test 3: two loads in one frame, last word wins, single ack
    acks = 0;
    while (cyc < 58) begin
      adv();
      acks += int'(load_ack);
      if (cyc == 39) begin value_in = 16'h1111; value_load = 1'b1; end
      if (cyc == 40) value_load = 1'b0;
      if (cyc == 44) begin value_in = 16'hABCD; value_load = 1'b1; end
      if (cyc == 45) value_load = 1'b0;
    end
    chk("t3_ack_at_fd", {31'd0, load_ack}, 32'd1);
    chk("t3_ack_count", acks, 32'd1);
    adv_to(61); chk_slot("t3_d0", 4'b1110, 7'b1000010);
    adv_to(66); chk_slot("t3_d1", 4'b1101, 7'b0110001);
    adv_to(71); chk_slot("t3_d2", 4'b1011, 7'b1100000);
    adv_to(76); chk_slot("t3_d3", 4'b0111, 7'b0001000);

    // Test 4: load strobe inside the boundary cycle
    adv_to(77);
    @(posedge clk);
    #1;
    value_in   = 16'hE975;
    value_load = 1'b1;
    adv_to(78);
    chk("t4_fd", {31'd0, frame_done}, 32'd1);
    chk("t4_ack", {31'd0, load_ack}, 32'd1);
    @(posedge clk);
    #1;
    value_load = 1'b0;
    adv_to(81); chk_slot("t4_d0", 4'b1110, 7'b0100100);
    adv_to(86); chk_slot("t4_d1", 4'b1101, 7'b0001111);
    adv_to(91); chk_slot("t4_d2", 4'b1011, 7'b0000100);
    adv_to(96); chk_slot("t4_d3", 4'b0111, 7'b0110000);
    adv_to(98);
    chk("t4_fd_next", {31'd0, frame_done}, 32'd1);
    chk("t4_noack_next", {31'd0, load_ack}, 32'd0);

    // Test 5: disabled digits keep anodes off, timing unchanged
    dig_en = 4'b0101;
    adv_to(101); chk_slot("t5_d0", 4'b1110, 7'b0100100);
    adv_to(106); chk("t5_d1_first", {28'd0, an}, 32'hF);
    adv_to(109); chk("t5_d1_last", {28'd0, an}, 32'hF);
    adv_to(111); chk_slot("t5_d2", 4'b1011, 7'b0000100);
    adv_to(116); chk("t5_d3_first", {28'd0, an}, 32'hF);
    adv_to(118);
    chk("t5_fd", {31'd0, frame_done}, 32'd1);
    chk("t5_d3_fd_an", {28'd0, an}, 32'hF);
    adv_to(119); chk("t5_d3_last", {28'd0, an}, 32'hF);

    // Test 6: reset during digit 2 discards the pending word
    adv_to(120);
    value_in   = 16'h4444;
    value_load = 1'b1;
    adv_to(121);
    value_load = 1'b0;
    adv_to(131);
    chk_slot("t6_d2", 4'b1011, 7'b0000100);
    rst = 1'b1;
    adv_to(132);
    chk_slot("t6_rst", 4'b1111, 7'b1111111);
    chk("t6_rst_ack", {31'd0, load_ack}, 32'd0);
    chk("t6_rst_fd", {31'd0, frame_done}, 32'd0);
    rst    = 1'b0;
    cyc    = -1;
    acks   = 0;
    fdones = 0;
    while (cyc < 45) begin
      adv();
      acks   += int'(load_ack);
      fdones += int'(frame_done);
      if (cyc == 1) chk_slot("t6_after_d0", 4'b1110, 7'b0000001);
    end
    chk("t6_no_ack", acks, 32'd0);
    chk("t6_fd_count", fdones, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
